// File: rtl/mpi_resp_txfifo.sv
// MPI (Q-bus, inverted AD) responder with CSR/DATA registers feeding a TX byte FIFO.
// Optional IRQ output is built only when MPI_RESP_IRQ_EN is defined.
module mpi_resp_txfifo #(
  parameter logic [15:0] BASE_ADDR   = 16'o177700,
  parameter int          WAIT_STATES = 1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic [15:0] pin_ad_n_i,
  output logic [15:0] pin_ad_n_o,
  output logic        pin_ad_oe,
  input  logic        pin_sync_n,
  input  logic        pin_din_n,
  input  logic        pin_dout_n,
  input  logic        pin_wtbt_n,
  output logic        pin_rply_n,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        pin_irq_n
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_SEL, S_WAIT, S_RPLY} state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          rd_q, rd_d;
  logic          rply_n_q, rply_n_d;
  logic          oe_q, oe_d;
  logic [15:0]   ad_n_o_q, ad_n_o_d;
  logic          wr_act;

  logic          ie_q, ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;

  logic [15:0]   wdata, rdata;
  logic          byte_w, hi_byte, full, pop, push, push_req, csr_wr, flush;
  logic [7:0]    push_byte;
  logic [4:0]    cnt5;

  assign wdata     = ~pin_ad_n_i;
  assign byte_w    = ~pin_wtbt_n;
  assign hi_byte   = byte_w & addr_q[0];
  assign full      = (cnt_q == FULL_CNT);
  assign cnt5      = 5'(cnt_q);
  assign rdata     = addr_q[1] ? 16'o000000
                               : {ovf_q, 7'b0, ~full, ie_q, 1'b0, cnt5};
  assign push_req  = wr_act & addr_q[1];
  assign push_byte = hi_byte ? wdata[15:8] : wdata[7:0];
  // A CSR byte write to the odd address touches only bit 15 (OVF), which is read-only.
  assign csr_wr    = wr_act & ~addr_q[1] & ~hi_byte;
  assign flush     = csr_wr & wdata[0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    rd_d     = rd_q;
    rply_n_d = rply_n_q;
    oe_d     = oe_q;
    ad_n_o_d = ad_n_o_q;
    wr_act   = 1'b0;
    case (state_q)
      S_IDLE: if (!pin_sync_n) begin
        addr_d  = wdata;
        state_d = (wdata[15:2] == BASE_ADDR[15:2]) ? S_SEL : S_SKIP;
      end
      S_SKIP: if (pin_sync_n) state_d = S_IDLE;
      S_SEL: if (!pin_din_n || !pin_dout_n) begin
        wcnt_d  = 3'(WAIT_STATES);
        rd_d    = ~pin_din_n;
        state_d = S_WAIT;
        if (!pin_din_n) begin
          oe_d     = 1'b1;
          ad_n_o_d = ~rdata;
        end
      end
      S_WAIT: if (wcnt_q == 3'd0) begin
        rply_n_d = 1'b0;
        state_d  = S_RPLY;
        if (rd_q) ad_n_o_d = ~rdata;
        else      wr_act   = 1'b1;
      end else begin
        wcnt_d = wcnt_q - 3'd1;
      end
      S_RPLY: if (rd_q ? pin_din_n : pin_dout_n) begin
        rply_n_d = 1'b1;
        oe_d     = 1'b0;
        ad_n_o_d = 16'hFFFF;
        state_d  = S_SEL;
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping SYNC aborts whatever transfer is in flight.
    if (pin_sync_n && state_q != S_IDLE && state_q != S_SKIP) begin
      state_d  = S_IDLE;
      rply_n_d = 1'b1;
      oe_d     = 1'b0;
      ad_n_o_d = 16'hFFFF;
      wr_act   = 1'b0;
    end
  end

  always_comb begin
    pop    = tx_valid_q & tx_ready;
    push   = push_req & (~full | pop);
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (pop) rptr_d = rptr_q + 1'b1;
      if (push) begin
        mem_d[wptr_q] = push_byte;
        wptr_d        = wptr_q + 1'b1;
      end
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push_req && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wcnt_q     <= '0;
      rd_q       <= 1'b0;
      rply_n_q   <= 1'b1;
      oe_q       <= 1'b0;
      ad_n_o_q   <= 16'hFFFF;
      ie_q       <= 1'b0;
      ovf_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      rd_q       <= rd_d;
      rply_n_q   <= rply_n_d;
      oe_q       <= oe_d;
      ad_n_o_q   <= ad_n_o_d;
      if (csr_wr) ie_q <= wdata[6];
      ovf_q      <= ovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= mem_d[rptr_d];
      tx_valid_q <= (cnt_d != '0);
    end
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge pin_clk) begin
    mem_q <= mem_d;
  end

  assign pin_ad_n_o = ad_n_o_q;
  assign pin_ad_oe  = oe_q;
  assign pin_rply_n = rply_n_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;

`ifdef MPI_RESP_IRQ_EN
  logic irq_n_q;
  always_ff @(posedge pin_clk) begin
    if (pin_rst) irq_n_q <= 1'b1;
    else         irq_n_q <= ~(ie_q & ~full & ~tx_valid_q);
  end
  assign pin_irq_n = irq_n_q;
`else
  assign pin_irq_n = 1'b1;
`endif
endmodule

// File: tb/tb_mpi_resp_txfifo.sv
// Randomized bench for mpi_resp_txfifo against a queue-based model of the registers and FIFO.
module tb_mpi_resp_txfifo;
  localparam logic [15:0] BASE = 16'o177700;
  localparam int WS    = 1;
  localparam int DEPTH = 4;
`ifdef MPI_RESP_IRQ_EN
  localparam logic IRQ_ON = 1'b0;
`else
  localparam logic IRQ_ON = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ad_n_i = 16'hFFFF;
  logic [15:0] ad_n_o;
  logic        oe, rply_n, tx_valid, irq_n;
  logic        sync_n = 1'b1, din_n = 1'b1, dout_n = 1'b1, wtbt_n = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ie = 1'b0;
  logic       m_ovf = 1'b0;

  always #5 clk = ~clk;

  mpi_resp_txfifo #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .FIFO_DEPTH(DEPTH)) dut (
    .pin_clk(clk), .pin_rst(rst), .pin_ad_n_i(ad_n_i), .pin_ad_n_o(ad_n_o),
    .pin_ad_oe(oe), .pin_sync_n(sync_n), .pin_din_n(din_n), .pin_dout_n(dout_n),
    .pin_wtbt_n(wtbt_n), .pin_rply_n(rply_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .pin_irq_n(irq_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_csr();
    return {m_ovf, 7'b0, logic'(q.size() != DEPTH), m_ie, 1'b0, 5'(q.size())};
  endfunction

  task automatic m_write(input logic [15:0] a, input bit bw, input logic [15:0] wd);
    logic [7:0] b;
    if (a[1]) begin
      b = (bw && a[0]) ? wd[15:8] : wd[7:0];
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(b);
    end else if (!(bw && a[0])) begin
      m_ie = wd[6];
      if (wd[0]) begin
        q.delete();
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ie = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One full responder transfer; pop_mid pops the head on the same edge as the push.
  task automatic bus(input logic [15:0] a, input bit rd, input bit bw,
                     input logic [15:0] wd, input bit pop_mid, output logic [15:0] rv);
    int i;
    rv = 16'h0;
    @(negedge clk);
    sync_n = 1'b0;
    ad_n_i = ~a;
    @(negedge clk);
    if (rd) begin
      din_n = 1'b0;
      ad_n_i = 16'hFFFF;
    end else begin
      dout_n = 1'b0;
      ad_n_i = ~wd;
      wtbt_n = ~bw;
    end
    i = 0;
    do begin
      @(negedge clk);
      i++;
      if (i == 1) chk("oe_entry", oe, rd);
      if (pop_mid && i == WS + 1 && q.size() != 0) begin
        chk("head_pp", tx_data, q[0]);
        tx_ready = 1'b1;
        void'(q.pop_front());
      end
      if (i == WS + 2) tx_ready = 1'b0;
    end while (rply_n && i < 20);
    tx_ready = 1'b0;
    chk("rply_lat", i, WS + 2);
    chk("oe_rply", oe, rd);
    if (rd) rv = ~ad_n_o;
    else m_write(a, bw, wd);
    din_n = 1'b1;
    dout_n = 1'b1;
    wtbt_n = 1'b1;
    ad_n_i = 16'hFFFF;
    @(negedge clk);
    chk("rply_rel", {rply_n, oe}, 2'b10);
    sync_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int n, input bit always_rdy);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("tx_valid", tx_valid, q.size() != 0);
      if (q.size() != 0) chk("tx_data", tx_data, q[0]);
      tx_ready = always_rdy ? 1'b1 : 1'($urandom % 2);
      if (tx_ready && q.size() != 0) void'(q.pop_front());
    end
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic rd_csr(input string tag);
    logic [15:0] v, e;
    e = m_csr();
    bus(BASE, 1'b1, 1'b0, 16'h0, 1'b0, v);
    chk(tag, v, e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    int i;
    do_reset();
    @(negedge clk);
    chk("rst_out", {rply_n, oe, ad_n_o, tx_valid, irq_n}, {1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1});

    // Idle CSR read: READY only
    bus(BASE, 1'b1, 1'b0, 16'h0, 1'b0, v);
    chk("csr_reset", v, 16'o000200);

    // Overfill with tx_ready low
    repeat (5) bus(BASE + 16'd2, 1'b0, 1'b0, 16'o000101, 1'b0, v);
    rd_csr("csr_ovf");
    chk("ovf_head", tx_data, 8'o101);

    // Flush, then high-byte DATOB
    bus(BASE, 1'b0, 1'b0, 16'o000001, 1'b0, v);
    bus(BASE + 16'd3, 1'b0, 1'b1, 16'h5A00, 1'b0, v);
    rd_csr("csr_one");
    drain(2, 1'b1);

    // Full FIFO with simultaneous push and pop
    for (int k = 0; k < DEPTH; k++) bus(BASE + 16'd2, 1'b0, 1'b0, 16'(8'h10 + k), 1'b0, v);
    bus(BASE + 16'd2, 1'b0, 1'b0, 16'h00EE, 1'b1, v);
    rd_csr("csr_pp");
    drain(DEPTH + 2, 1'b1);
    for (int k = 0; k < DEPTH + 1; k++) bus(BASE + 16'd2, 1'b0, 1'b0, 16'(8'h30 + k), 1'b0, v);
    bus(BASE, 1'b0, 1'b0, 16'o000001, 1'b0, v);
    rd_csr("csr_flush");

    // Unmapped address: never replies or drives
    @(negedge clk);
    sync_n = 1'b0; ad_n_i = ~16'o177600;
    @(negedge clk);
    din_n = 1'b0; ad_n_i = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("skip_quiet", {rply_n, oe}, 2'b10);
    end
    din_n = 1'b1; sync_n = 1'b1;
    @(negedge clk);

    // Abort during WAIT
    sync_n = 1'b0; ad_n_i = ~BASE;
    @(negedge clk);
    din_n = 1'b0; ad_n_i = 16'hFFFF;
    @(negedge clk);
    chk("abort_oe", oe, 1'b1);
    sync_n = 1'b1; din_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_idle", {rply_n, oe}, 2'b10);
    end

    // Reset while in RPLY
    bus(BASE + 16'd2, 1'b0, 1'b0, 16'h0077, 1'b0, v);
    @(negedge clk);
    sync_n = 1'b0; ad_n_i = ~BASE;
    @(negedge clk);
    din_n = 1'b0; ad_n_i = 16'hFFFF;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (rply_n && i < 20);
    chk("rst_rply_lat", i, WS + 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_rply", {rply_n, oe, ad_n_o, tx_valid}, {1'b1, 1'b0, 16'hFFFF, 1'b0});
    rst = 1'b0; din_n = 1'b1; sync_n = 1'b1;
    q.delete(); m_ie = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    rd_csr("csr_after_rst");

    // Interrupt on drain
    bus(BASE, 1'b0, 1'b0, 16'o000100, 1'b0, v);
    bus(BASE + 16'd2, 1'b0, 1'b0, 16'h0042, 1'b0, v);
    repeat (3) @(negedge clk);
    chk("irq_busy", irq_n, 1'b1);
    tx_ready = 1'b1;
    void'(q.pop_front());
    @(negedge clk);
    tx_ready = 1'b0;
    chk("irq_valid_fall", {tx_valid, irq_n}, 2'b01);
    @(negedge clk);
    chk("irq_assert", irq_n, IRQ_ON);
    bus(BASE, 1'b0, 1'b0, 16'o000000, 1'b0, v);
    chk("irq_clear", irq_n, 1'b1);
    rd_csr("csr_irq_end");

    // Random mix
    for (int it = 0; it < 150; it++) begin
      int op;
      logic [15:0] d;
      op = int'($urandom_range(0, 5));
      d = 16'($urandom);
      case (op)
        0: bus(BASE + 16'd2, 1'b0, 1'b0, d, ($urandom % 3 == 0) && q.size() != 0, v);
        1: bus(BASE + 16'd2 + 16'($urandom % 2), 1'b0, 1'b1, d, 1'b0, v);
        2: rd_csr("rnd_csr");
        3: begin
          bus(BASE + 16'd2, 1'b1, 1'b0, 16'h0, 1'b0, v);
          chk("rnd_data_rd", v, 16'o000000);
        end
        4: begin
          if ($urandom % 4 != 0) d[0] = 1'b0;
          bus(BASE + 16'($urandom % 2), 1'b0, 1'($urandom % 2), d, 1'b0, v);
        end
        default: drain(int'($urandom_range(1, 6)), 1'b0);
      endcase
    end
    rd_csr("final_csr");
    drain(DEPTH + 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
